// File: rtl/packed_sat_alu.sv
// packed_sat_alu: two-stage packed-SIMD add/subtract unit.
// Per-lane signed saturation or wrap, per-lane overflow, sticky overflow.
module packed_sat_alu #(
    parameter int LANE_W = 4,
    parameter int LANES  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                op,
    input  logic [LANES*LANE_W-1:0]   a,
    input  logic [LANES*LANE_W-1:0]   b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   result,
    output logic [LANES-1:0]          ovf,
    input  logic                      clr_sticky,
    output logic                      sticky_ovf
);

    localparam int W   = LANES * LANE_W;
    localparam int MSB = LANE_W - 1;

    logic            v1;
    logic [W-1:0]    a1;
    logic [W-1:0]    b1;
    logic [1:0]      op1;
    logic            v2;
    logic            s1_en;
    logic            s2_en;
    logic [W-1:0]    lane_res;
    logic [LANES-1:0] lane_ovf;

    assign s2_en     = ~v2 | out_ready;
    assign s1_en     = ~v1 | s2_en;
    assign in_ready  = s1_en;
    assign out_valid = v2;

    // S1: capture operands on accept, insert a bubble otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            a1  <= '0;
            b1  <= '0;
            op1 <= '0;
        end else if (s1_en) begin
            v1 <= in_valid;
            if (in_valid) begin
                a1  <= a;
                b1  <= b;
                op1 <= op;
            end
        end
    end

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] x;
        logic [LANE_W-1:0] y;
        logic [LANE_W-1:0] yb;
        logic [LANE_W-1:0] r;
        logic [LANE_W-1:0] clamp;
        logic              o;

        assign x  = a1[g*LANE_W +: LANE_W];
        assign y  = b1[g*LANE_W +: LANE_W];
        assign yb = op1[0] ? ~y : y;
        assign r  = x + yb + LANE_W'(op1[0]);

        // Subtract overflows only when operand signs differ; add when they match.
        assign o = (op1[0] ? (x[MSB] != y[MSB]) : (x[MSB] == y[MSB]))
                   && (r[MSB] != x[MSB]);

        // Clamp direction follows the sign of x, never the carry-out.
        assign clamp = x[MSB] ? {1'b1, {(LANE_W-1){1'b0}}}
                              : {1'b0, {(LANE_W-1){1'b1}}};

        assign lane_res[g*LANE_W +: LANE_W] = (o && !op1[1]) ? clamp : r;
        assign lane_ovf[g] = o;
    end

    // S2: hold the presented beat until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            v2     <= 1'b0;
            result <= '0;
            ovf    <= '0;
        end else if (s2_en) begin
            v2 <= v1;
            if (v1) begin
                result <= lane_res;
                ovf    <= lane_ovf;
            end
        end
    end

    // Sticky flag: a delivery with overflow wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf <= 1'b0;
        end else begin
            sticky_ovf <= (clr_sticky ? 1'b0 : sticky_ovf)
                        | (out_valid & out_ready & (|ovf));
        end
    end

endmodule

// File: tb/tb_packed_sat_alu.sv
// tb_packed_sat_alu: randomized scoreboard bench for packed_sat_alu.
// Expected beats come from an integer-arithmetic lane model.
module tb_packed_sat_alu;

    localparam int LW = 4;
    localparam int NL = 4;
    localparam int W  = LW * NL;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic [NL-1:0] ovf;
    logic          clr_sticky;
    logic          sticky_ovf;

    packed_sat_alu #(.LANE_W(LW), .LANES(NL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .ovf        (ovf),
        .clr_sticky (clr_sticky),
        .sticky_ovf (sticky_ovf)
    );

    typedef struct {
        logic [W-1:0]  res;
        logic [NL-1:0] ovf;
        int            acc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    bit   sticky_m = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: true signed sum/difference, then clamp or wrap.
    function automatic exp_t model(input logic [W-1:0] ma,
                                   input logic [W-1:0] mb,
                                   input logic [1:0] mop);
        exp_t e;
        int mx;
        int mn;
        mx = (1 << (LW - 1)) - 1;
        mn = -(1 << (LW - 1));
        e.res = '0;
        e.ovf = '0;
        e.acc = 0;
        for (int i = 0; i < NL; i++) begin
            logic [LW-1:0] xl;
            logic [LW-1:0] yl;
            int x;
            int y;
            int s;
            int r;
            logic [31:0] rv;
            xl = ma[i*LW +: LW];
            yl = mb[i*LW +: LW];
            x = int'($signed(xl));
            y = int'($signed(yl));
            s = mop[0] ? x - y : x + y;
            e.ovf[i] = (s > mx) || (s < mn);
            r = s;
            if (e.ovf[i] && !mop[1]) r = (s > mx) ? mx : mn;
            rv = r;
            e.res[i*LW +: LW] = rv[LW-1:0];
        end
        return e;
    endfunction

    task automatic fail_line(input string name, input logic [31:0] act,
                             input logic [31:0] req);
        n_bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, req);
    endtask

    // Record each accepted beat after the monitor has looked at this edge.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            exp_t e;
            e = model(a, b, op);
            e.acc = cyc;
            #1 q.push_back(e);
        end
    end

    // Monitor: handshake, presented beat and sticky flag against the model.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            sticky_m = 0;
        end else begin
            bit fire;
            bit ovf_any;
            bit exp_v;
            bit exp_r;
            fire = 0;
            ovf_any = 0;
            exp_r = (q.size() < 2) || out_ready;
            n_cmp++;
            if (in_ready !== exp_r) fail_line("in_ready", 32'(in_ready), 32'(exp_r));
            exp_v = (q.size() > 0) && (cyc >= q[0].acc + 2);
            n_cmp++;
            if (out_valid !== exp_v) fail_line("out_valid", 32'(out_valid), 32'(exp_v));
            if (exp_v) begin
                n_cmp++;
                if (result !== q[0].res) fail_line("result", 32'(result), 32'(q[0].res));
                n_cmp++;
                if (ovf !== q[0].ovf) fail_line("ovf", 32'(ovf), 32'(q[0].ovf));
                if (out_ready) begin
                    fire = 1;
                    ovf_any = |q[0].ovf;
                    void'(q.pop_front());
                end
            end
            n_cmp++;
            if (sticky_ovf !== sticky_m) fail_line("sticky", 32'(sticky_ovf), 32'(sticky_m));
            sticky_m = (clr_sticky ? 1'b0 : sticky_m) | (fire & ovf_any);
        end
    end

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [1:0] top);
        bit done;
        done = 0;
        in_valid = 1;
        a = ta;
        b = tb;
        op = top;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        if (!done) begin
            n_cmp++;
            fail_line("accept_timeout", 0, 1);
        end
    endtask

    task automatic drain();
        int k;
        out_ready = 1;
        k = 0;
        while (q.size() > 0 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_cmp++;
        if (q.size() != 0) fail_line("drain_timeout", 32'(q.size()), 0);
    endtask

    initial begin
        rst = 1;
        in_valid = 0;
        op = 0;
        a = 0;
        b = 0;
        out_ready = 1;
        clr_sticky = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        send(16'h718F, 16'h118F, 2'b00);
        send(16'h718F, 16'h118F, 2'b10);
        send(16'h8705, 16'h1F83, 2'b01);
        send(16'h7F80, 16'h0101, 2'b00);
        send(16'h8888, 16'h7777, 2'b11);
        drain();
        repeat (2) @(posedge clk);
        #1;

        out_ready = 0;
        fork
            begin
                send(16'h7777, 16'h1111, 2'b00);
                send(16'h8888, 16'h1111, 2'b01);
                send(16'h1234, 16'h4321, 2'b10);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();

        clr_sticky = 1;
        @(posedge clk);
        #1 clr_sticky = 0;
        out_ready = 0;
        send(16'h7777, 16'h1111, 2'b00);
        @(posedge clk);
        #1;
        clr_sticky = 1;
        out_ready = 1;
        @(posedge clk);
        #1 clr_sticky = 0;
        drain();
        repeat (2) @(posedge clk);
        #1;

        out_ready = 0;
        send(16'h7777, 16'h1111, 2'b00);
        send(16'h8888, 16'h8888, 2'b00);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        out_ready = 1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 1500; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            op = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_sticky = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        clr_sticky = 0;
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
